// File: rtl/ee457_mem_pkg.sv
// Shared definitions for the EE457 instruction/data memory arbiter.
// Holds the FSM encoding, the port-select type and the grant decision.
package ee457_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_t;

  // Data wins unless fetch is pending and has already been passed over STARVE_MAX times.
  function automatic sel_t arbitrate(input logic i_pend, input logic d_pend,
                                     input logic starve_ok);
    return (d_pend && (!i_pend || starve_ok)) ? SEL_D : SEL_I;
  endfunction

endpackage

// File: rtl/ee457_req_hold.sv
// Sticky completion register for one requester: remembers the last served
// access and reports a hit while the requester keeps presenting it.
module ee457_req_hold
  import ee457_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] req_addr,
  input  logic          req_write,
  input  logic [DW-1:0] req_wdata,
  input  logic          capture,
  input  logic [AW-1:0] cap_addr,
  input  logic          cap_write,
  input  logic [DW-1:0] cap_wdata,
  input  logic          inval,
  input  logic [AW-1:0] inval_addr,
  output logic          hit
);

  logic          hold;
  logic          hold_write;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  // Store data only matters for stores; a load hit ignores the wdata bus.
  assign hit = hold & req & (req_addr == hold_addr) & (req_write == hold_write) &
               (~hold_write | (req_wdata == hold_wdata));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold       <= 1'b0;
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (capture) begin
      hold       <= 1'b1;
      hold_write <= cap_write;
      hold_addr  <= cap_addr;
      hold_wdata <= cap_wdata;
    end else if (!hit || (inval && (inval_addr == hold_addr))) begin
      hold <= 1'b0;
    end
  end

endmodule

// File: rtl/ee457_mem_arbiter.sv
// Serialises CPU instruction-fetch and data accesses onto one single-port
// memory and freezes the pipeline until every outstanding access is done.
module ee457_mem_arbiter
  import ee457_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_req,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_read,
  input  logic          d_write,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          i_hit, d_hit;
  logic          i_pend, d_pend;
  logic          i_done, d_done;
  sel_t          sel;

  assign i_pend = i_req & ~i_hit;
  assign d_pend = (d_read | d_write) & ~d_hit;
  assign i_done = (state == IBUSY) & mem_ack;
  assign d_done = (state == DBUSY) & mem_ack;
  assign sel    = arbitrate(i_pend, d_pend, cnt < CNT_MAX);

  assign i_ready = i_hit;
  assign d_ready = d_hit;
  assign stall   = i_pend | d_pend | (state != IDLE);

  // A completed store to the held fetch address invalidates it, forcing a re-fetch.
  ee457_req_hold #(.AW(AW), .DW(DW)) u_i_hold (
    .clk        (clk),
    .rst        (rst),
    .req        (i_req),
    .req_addr   (i_addr),
    .req_write  (1'b0),
    .req_wdata  ('0),
    .capture    (i_done),
    .cap_addr   (mem_addr),
    .cap_write  (1'b0),
    .cap_wdata  ('0),
    .inval      (d_done & mem_write),
    .inval_addr (mem_addr),
    .hit        (i_hit)
  );

  ee457_req_hold #(.AW(AW), .DW(DW)) u_d_hold (
    .clk        (clk),
    .rst        (rst),
    .req        (d_read | d_write),
    .req_addr   (d_addr),
    .req_write  (d_write),
    .req_wdata  (d_wdata),
    .capture    (d_done),
    .cap_addr   (mem_addr),
    .cap_write  (mem_write),
    .cap_wdata  (mem_wdata),
    .inval      (1'b0),
    .inval_addr ('0),
    .hit        (d_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_pend || i_pend) begin
            if (sel == SEL_D) begin
              state     <= DBUSY;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_read  <= d_read;
              mem_write <= d_write;
              if (i_pend) cnt <= cnt + 1'b1;
            end else begin
              state     <= IBUSY;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              cnt       <= '0;
            end
          end
        end
        IBUSY: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            i_rdata  <= mem_rdata;
          end
        end
        DBUSY: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) d_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ee457_mem_arbiter.md
Name: ee457_mem_arbiter

Overview:
- Shares one unified single-port memory between the pipelined CPU's instruction-fetch port and data port.
- Accepts independent I/D requests, serialises them onto the memory with a req/ack handshake, and returns read data to each requester.
- Generates the global pipeline stall that freezes the CPU until every outstanding access has completed.
- Sits between the CPU's imem_*/dmem_* ports and the memory model.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, max consecutive D grants while I is pending before I is forced

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_addr  in  AW  fetch address
- i_req  in  1  fetch request, held until i_ready
- i_rdata  out  DW  fetched instruction, valid while i_ready=1
- i_ready  out  1  fetch complete
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_read  in  1  load request
- d_write  in  1  store request; never asserted together with d_read
- d_rdata  out  DW  load data, valid while d_ready=1
- d_ready  out  1  data access complete
- stall  out  1  pipeline freeze
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_read  out  1  memory read command, registered
- mem_write  out  1  memory write command, registered
- mem_rdata  in  DW  memory read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset: asynchronous on rst=0. Clears state to IDLE, STARVE count to 0 and both hold flags. All outputs go to 0: i_ready, d_ready, mem_read, mem_write, mem_addr, mem_wdata, i_rdata, d_rdata. stall is combinational and follows the stall equation below.
- Pending conditions:
  - i_pend = i_req & ~i_hold_hit
  - d_pend = (d_read|d_write) & ~d_hold_hit
- FSM states: IDLE, IBUSY, DBUSY.
  - IDLE: grant D if d_pend and (~i_pend or cnt<STARVE_MAX). Otherwise grant I if i_pend. Otherwise stay IDLE.
  - On grant, register mem_addr/mem_wdata/mem_read/mem_write at the clock edge and go to the BUSY state.
  - cnt increments on each D grant made while i_pend=1, and clears on any I grant.
  - IBUSY/DBUSY: hold all mem_* outputs stable until mem_ack=1.
  - On the ack edge: deassert mem_read/mem_write; capture mem_rdata into i_rdata or d_rdata (loads and fetches only); record the served address and op in the hold register; return to IDLE.
  - The granted-in-IDLE check is therefore skipped in the cycle after completion.
- Minimum latency: request seen in IDLE at cycle 0 → command on memory in cycle 1 → mem_ack in cycle 1 → ready=1 in cycle 2.
- Hold registers (sticky completion):
  - i_hold_hit = i_hold & i_req & (i_addr==i_hold_addr).
  - d_hold_hit = d_hold & same addr & same op & (for stores) same wdata.
  - i_ready = i_hold_hit; d_ready = d_hold_hit.
  - A completed access therefore stays ready while the CPU stays frozen on it, and is never re-issued.
  - A hold clears when the requester's address/op changes or its request drops.
- Stall equation: stall = i_pend | d_pend | (state!=IDLE). Combinational.
- Write coherence: a completed D store whose address equals i_hold_addr clears i_hold in the same edge, forcing a re-fetch.
- mem_ack while in IDLE is ignored.
- Async reset mid-access abandons the access. The memory must tolerate the command dropping.

Decomposition:
- Shared package ee457_mem_pkg: state encoding (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2) and the port-select constants.
- One natural sub-module: ee457_req_hold, instantiated twice. It holds one requester's served-address/op register and implements the hit compare and clear logic.

Test Plan:
- Single fetch, i_addr=0x40, mem_ack 3 cycles after the command → mem_read=1 at cycle 1 held through the ack; i_ready=1, i_rdata=mem word and stall=0 at cycle 5; the hold stays valid while i_addr=0x40.
- Simultaneous fetch 0x100 and load 0x2000 → D served first; I command issued immediately after the D ack; stall high until both ready; no access repeated.
- Continuous distinct D loads with i_req stuck at 0x8 → the 5th grant goes to I (STARVE_MAX=4); cnt then resets.
- Store 0x8 with data 0xDEADBEEF while the I hold is on 0x8 → i_ready drops, I re-fetches 0x8 and returns 0xDEADBEEF.
- rst=0 asserted during DBUSY → mem_write and all ready outputs go to 0 immediately (asynchronous); after release, state is IDLE and the pending request is re-issued.
